mul_div_unit: RTL and testbench

- Parametrised iterative multiply/divide unit with architectural HI/LO registers. It sits beside the single-cycle ALU in the EX stage of the MIPS core.
- Executes MULT/MULTU/DIV/DIVU over multiple cycles using a radix-2 shift-add/restoring datapath, and MTHI/MTLO in a single cycle.
- Uses a valid/ready request handshake, a completion pulse and a cancel input for exception flush.

---
 rtl/mdu_pkg.sv | 24 ++
 rtl/mul_div_unit.sv | 183 ++++++++++++++++++
 tb/tb_mul_div_unit.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared types for the iterative multiply/divide unit: opcodes and FSM states.
package mdu_pkg;

    typedef enum logic [2:0] {
        MDU_MULT  = 3'd0,
        MDU_MULTU = 3'd1,
        MDU_DIV   = 3'd2,
        MDU_DIVU  = 3'd3,
        MDU_MTHI  = 3'd4,
        MDU_MTLO  = 3'd5
    } mdu_op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MUL   = 2'd1,
        DIV   = 2'd2,
        FIXUP = 2'd3
    } mdu_state_t;

    function automatic logic op_is_signed(mdu_op_t op);
        return (op == MDU_MULT) || (op == MDU_DIV);
    endfunction

endpackage

// File: rtl/mul_div_unit.sv
// Radix-2 iterative multiply/divide unit with architectural HI/LO registers,
// sitting beside the single-cycle ALU in the EX stage.
//
// state | meaning
// IDLE  | waiting for a request; MTHI/MTLO complete here in one edge
// MUL   | WIDTH shift-add iterations on operand magnitudes
// DIV   | WIDTH restoring-division iterations on operand magnitudes
// FIXUP | apply result signs / divide-by-zero value, commit HI/LO, pulse done
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  mdu_op_t          req_op,
    input  logic [WIDTH-1:0] req_src_1,
    input  logic [WIDTH-1:0] req_src_2,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int               CNT_W    = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    mdu_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mq;
    logic [WIDTH-1:0] opnd;
    logic [WIDTH-1:0] src1_q;
    logic             op_div;
    logic             neg_res;
    logic             neg_rem;
    logic             div_zero;
    logic [WIDTH-1:0] hi_q, lo_q;
    logic             done_q;

    logic             accept;
    logic             req_signed;
    logic [WIDTH-1:0] mag_1, mag_2;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic             div_ge;
    logic [WIDTH-1:0] div_diff;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0] quot_fix, rem_fix;

    assign accept     = req_valid && (state == IDLE) && !cancel;
    assign req_signed = op_is_signed(req_op);

    // Two's-complement magnitude: the most-negative value wraps to 2^(WIDTH-1).
    assign mag_1 = (req_signed && req_src_1[WIDTH-1]) ? (~req_src_1) + WIDTH'(1) : req_src_1;
    assign mag_2 = (req_signed && req_src_2[WIDTH-1]) ? (~req_src_2) + WIDTH'(1) : req_src_2;

    assign mul_sum   = {1'b0, acc} + (mq[0] ? {1'b0, opnd} : '0);
    assign div_shift = {acc, mq[WIDTH-1]};
    assign div_ge    = div_shift >= {1'b0, opnd};
    assign div_diff  = div_shift[WIDTH-1:0] - opnd;

    assign prod     = {acc, mq};
    assign prod_fix = neg_res ? (~prod) + (2*WIDTH)'(1) : prod;
    assign quot_fix = neg_res ? (~mq) + WIDTH'(1) : mq;
    assign rem_fix  = neg_rem ? (~acc) + WIDTH'(1) : acc;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    case (req_op)
                        MDU_MULT, MDU_MULTU: state_nxt = MUL;
                        MDU_DIV, MDU_DIVU:   state_nxt = DIV;
                        default:             state_nxt = IDLE;
                    endcase
                end
            end
            MUL, DIV: begin
                if (cancel) begin
                    state_nxt = IDLE;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = FIXUP;
                end
            end
            FIXUP:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state == IDLE);
        busy      = (state != IDLE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt      <= '0;
            acc      <= '0;
            mq       <= '0;
            opnd     <= '0;
            src1_q   <= '0;
            op_div   <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        cnt      <= '0;
                        acc      <= '0;
                        src1_q   <= req_src_1;
                        op_div   <= (req_op == MDU_DIV) || (req_op == MDU_DIVU);
                        neg_res  <= req_signed && (req_src_1[WIDTH-1] ^ req_src_2[WIDTH-1]);
                        neg_rem  <= req_signed && req_src_1[WIDTH-1];
                        div_zero <= (req_src_2 == '0);
                        case (req_op)
                            MDU_MULT, MDU_MULTU: begin
                                mq   <= mag_2;
                                opnd <= mag_1;
                            end
                            MDU_DIV, MDU_DIVU: begin
                                mq   <= mag_1;
                                opnd <= mag_2;
                            end
                            MDU_MTHI: hi_q <= req_src_1;
                            MDU_MTLO: lo_q <= req_src_1;
                            default: ;
                        endcase
                    end
                end
                MUL: begin
                    acc <= mul_sum[WIDTH:1];
                    mq  <= {mul_sum[0], mq[WIDTH-1:1]};
                    cnt <= cnt + CNT_W'(1);
                end
                DIV: begin
                    acc <= div_ge ? div_diff : div_shift[WIDTH-1:0];
                    mq  <= {mq[WIDTH-2:0], div_ge};
                    cnt <= cnt + CNT_W'(1);
                end
                FIXUP: begin
                    if (!cancel) begin
                        done_q <= 1'b1;
                        if (!op_div) begin
                            hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                            lo_q <= prod_fix[WIDTH-1:0];
                        end else if (div_zero) begin
                            hi_q <= src1_q;
                            lo_q <= '1;
                        end else begin
                            hi_q <= rem_fix;
                            lo_q <= quot_fix;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: a cycle-level reference model built from
// plain 64-bit arithmetic is compared every cycle, plus literal expectations.
module tb_mul_div_unit;
    import mdu_pkg::*;

    localparam int W = 32;

    logic          clock = 1'b0;
    logic          reset;
    logic          req_valid = 1'b0;
    logic          req_ready;
    mdu_op_t       req_op = MDU_MULT;
    logic [W-1:0]  req_src_1 = '0;
    logic [W-1:0]  req_src_2 = '0;
    logic          cancel = 1'b0;
    logic          busy;
    logic          done;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    mul_div_unit #(.WIDTH(W)) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_src_1 (req_src_1),
        .req_src_2 (req_src_2),
        .cancel    (cancel),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // {hi, lo} an operation must produce, straight from integer arithmetic.
    function automatic logic [63:0] model_result(mdu_op_t op, logic [31:0] a, logic [31:0] b);
        longint      sa, sb, q, r;
        logic [63:0] ua, ub, uq, ur;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (op)
            MDU_MULT:  return 64'(sa * sb);
            MDU_MULTU: return ua * ub;
            MDU_DIV: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            MDU_DIVU: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                uq = ua / ub;
                ur = ua % ub;
                return {ur[31:0], uq[31:0]};
            end
            default: return 64'h0;
        endcase
    endfunction

    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;
    logic         m_busy = 1'b0;
    logic         m_done = 1'b0;
    int           m_left = 0;
    logic [63:0]  m_res = '0;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_hi   = '0;
            m_lo   = '0;
            m_busy = 1'b0;
            m_done = 1'b0;
            m_left = 0;
        end else begin
            m_done = 1'b0;
            if (m_busy) begin
                if (cancel) begin
                    m_busy = 1'b0;
                end else if (m_left == 1) begin
                    {m_hi, m_lo} = m_res;
                    m_busy = 1'b0;
                    m_done = 1'b1;
                end else begin
                    m_left--;
                end
            end else if (req_valid && !cancel) begin
                case (req_op)
                    MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: begin
                        m_res  = model_result(req_op, req_src_1, req_src_2);
                        m_busy = 1'b1;
                        m_left = W + 1;
                    end
                    MDU_MTHI: m_hi = req_src_1;
                    MDU_MTLO: m_lo = req_src_1;
                    default: ;
                endcase
            end
        end
    end

    always @(negedge clock) begin
        check("model hi", hi, m_hi);
        check("model lo", lo, m_lo);
        check("model done", done, m_done);
        check("model busy", busy, m_busy);
        check("model req_ready", req_ready, !m_busy);
    end

    task automatic run_op(input string name, input mdu_op_t op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo, input bit b2b);
        int n;
        if (!b2b) @(negedge clock);
        req_valid = 1'b1;
        req_op    = op;
        req_src_1 = a;
        req_src_2 = b;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        req_src_1 = 32'hDEAD_BEEF;
        req_src_2 = 32'h0BAD_F00D;
        n = 0;
        for (int i = 1; i <= W + 6; i++) begin
            @(negedge clock);
            if (done) begin
                n = i;
                break;
            end
        end
        check({name, " latency"}, 64'(n), 64'(W + 2));
        check({name, " hi"}, hi, exp_hi);
        check({name, " lo"}, lo, exp_lo);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        bit saw_done;
        reset = 1'b1;
        repeat (2) @(negedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("reset hi", hi, 0);
        check("reset lo", lo, 0);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset req_ready", req_ready, 1);

        run_op("mult neg", MDU_MULT,  32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0);
        run_op("multu",    MDU_MULTU, 32'hFFFF_FFFF, 32'h2, 32'h0000_0001, 32'hFFFF_FFFE, 1);
        run_op("div -7/2", MDU_DIV,   32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
        run_op("divu 7/2", MDU_DIVU,  32'h7, 32'h2, 32'h1, 32'h3, 1);
        run_op("div ovf",  MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 0);
        run_op("divu /0",  MDU_DIVU,  32'h5, 32'h0, 32'h5, 32'hFFFF_FFFF, 0);
        run_op("div -7/0", MDU_DIV,   32'hFFFF_FFF9, 32'h0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 0);
        run_op("div 7/-2", MDU_DIV,   32'h7, 32'hFFFF_FFFE, 32'h1, 32'hFFFF_FFFD, 0);
        run_op("multu max", MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1, 0);
        run_op("mult minsq", MDU_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 0);
        run_op("mult -3*-5", MDU_MULT, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 32'h0, 32'hF, 0);

        // DIVU cancelled in its 10th busy cycle, with an MTHI attempt while busy
        @(negedge clock);
        req_valid = 1'b1;
        req_op    = MDU_DIVU;
        req_src_1 = 32'd100;
        req_src_2 = 32'd7;
        @(posedge clock);
        #1 req_valid = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clock);
            if (i == 3) begin
                req_valid = 1'b1;
                req_op    = MDU_MTHI;
                req_src_1 = 32'hDEAD_0000;
                check("mthi busy req_ready", req_ready, 0);
            end
            if (i == 4) begin
                req_valid = 1'b0;
                check("mthi busy hi", hi, 0);
            end
            if (i == 10) cancel = 1'b1;
        end
        @(posedge clock);
        #1 cancel = 1'b0;
        @(negedge clock);
        check("cancel req_ready", req_ready, 1);
        check("cancel busy", busy, 0);
        check("cancel hi", hi, 0);
        check("cancel lo", lo, 32'hF);
        saw_done = 0;
        repeat (W + 4) begin
            @(negedge clock);
            if (done) saw_done = 1;
        end
        check("cancel no done", 64'(saw_done), 0);

        // cancel during the final (sign fixup) cycle
        @(negedge clock);
        req_valid = 1'b1;
        req_op    = MDU_MULTU;
        req_src_1 = 32'd2;
        req_src_2 = 32'd3;
        @(posedge clock);
        #1 req_valid = 1'b0;
        for (int i = 1; i <= W + 1; i++) @(negedge clock);
        cancel = 1'b1;
        @(posedge clock);
        #1 cancel = 1'b0;
        @(negedge clock);
        check("fixup cancel done", done, 0);
        check("fixup cancel lo", lo, 32'hF);
        check("fixup cancel req_ready", req_ready, 1);

        // MTHI then MTLO on consecutive cycles
        @(negedge clock);
        req_valid = 1'b1;
        req_op    = MDU_MTHI;
        req_src_1 = 32'h1234_5678;
        @(posedge clock);
        #1 check("mthi hi", hi, 32'h1234_5678);
        check("mthi req_ready", req_ready, 1);
        @(negedge clock);
        req_op    = MDU_MTLO;
        req_src_1 = 32'h9ABC_DEF0;
        @(posedge clock);
        #1 check("mtlo lo", lo, 32'h9ABC_DEF0);
        check("mtlo hi", hi, 32'h1234_5678);
        check("mtlo done", done, 0);
        req_valid = 1'b0;

        // reserved opcode and cancel in IDLE leave HI/LO alone
        @(negedge clock);
        req_valid = 1'b1;
        req_op    = mdu_op_t'(3'd6);
        req_src_1 = 32'hFFFF_FFFF;
        @(negedge clock);
        req_op    = MDU_MTHI;
        req_src_1 = 32'h0000_0055;
        cancel    = 1'b1;
        @(negedge clock);
        req_valid = 1'b0;
        cancel    = 1'b0;
        check("idle block hi", hi, 32'h1234_5678);
        check("reserved lo", lo, 32'h9ABC_DEF0);
        check("reserved busy", busy, 0);

        // asynchronous reset in the middle of a MULT
        @(negedge clock);
        req_valid = 1'b1;
        req_op    = MDU_MULT;
        req_src_1 = 32'd7;
        req_src_2 = 32'd9;
        @(posedge clock);
        #1 req_valid = 1'b0;
        repeat (5) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        check("async reset hi", hi, 0);
        check("async reset lo", lo, 0);
        check("async reset busy", busy, 0);
        check("async reset done", done, 0);
        @(negedge clock);
        #1 reset = 1'b0;
        saw_done = 0;
        repeat (W + 4) begin
            @(negedge clock);
            if (done) saw_done = 1;
        end
        check("reset no done", 64'(saw_done), 0);
        run_op("mult 3*5", MDU_MULT, 32'd3, 32'd5, 32'h0, 32'hF, 0);

        @(negedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
